// File: rtl/eind_opdracht_design_led_fader_if.sv
// Pattern-in / LED-drive bundle between the PIO-side master and the LED fader.
// The master drives the pattern and the run controls; the fader returns the PWM drive and busy.
interface eind_opdracht_design_led_fader_if;
   logic [7:0] pattern;
   logic       enable;
   logic       snap;
   logic [7:0] led_out;
   logic       busy;

   modport master (output pattern, enable, snap, input led_out, busy);
   modport slave  (input pattern, enable, snap, output led_out, busy);
endinterface

// File: rtl/eind_opdracht_design_led_fader.sv
// LED fader: turns each on/off pattern bit into a linear brightness ramp with per-LED PWM.
// Levels step once per STEP_DIV enabled cycles toward 0 or MAX; snap jumps straight to the target.
module eind_opdracht_design_led_fader #(
   parameter int PWM_BITS = 8,
   parameter int STEP_DIV = 1000
) (
   input  logic                            clk,
   input  logic                            reset,
   eind_opdracht_design_led_fader_if.slave bus
);
   localparam int                  PRE_W    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
   localparam logic [PWM_BITS-1:0] MAX      = '1;
   localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(STEP_DIV - 1);

   logic [7:0]                pattern_q;
   logic [PRE_W-1:0]          pre_q, pre_d;
   logic [PWM_BITS-1:0]       pwm_cnt_q, pwm_cnt_d;
   logic [7:0][PWM_BITS-1:0]  level_q, level_d;
   logic [7:0][PWM_BITS-1:0]  target;
   logic [7:0]                led_out_q, led_out_d;
   logic [7:0]                differs;
   logic                      step_tick;

   // One step toward the target; cannot overshoot, so 0 and MAX are natural bounds.
   function automatic logic [PWM_BITS-1:0] step_toward(input logic [PWM_BITS-1:0] lvl,
                                                       input logic [PWM_BITS-1:0] tgt);
      if (lvl < tgt)      return lvl + 1'b1;
      else if (lvl > tgt) return lvl - 1'b1;
      else                return lvl;
   endfunction

   always_comb begin
      step_tick = bus.enable && (pre_q == PRE_LAST);
      pre_d     = pre_q;
      pwm_cnt_d = pwm_cnt_q;
      if (bus.enable) begin
         pre_d     = (pre_q == PRE_LAST) ? '0 : pre_q + 1'b1;
         pwm_cnt_d = pwm_cnt_q + 1'b1;
      end

      target    = '0;
      differs   = '0;
      level_d   = level_q;
      led_out_d = '0;
      for (int i = 0; i < 8; i++) begin
         target[i]  = pattern_q[i] ? MAX : '0;
         differs[i] = (level_q[i] != target[i]);
         // Snap has priority over a coincident step tick.
         if (bus.snap)
            level_d[i] = target[i];
         else if (step_tick)
            level_d[i] = step_toward(level_q[i], target[i]);
         led_out_d[i] = bus.enable && ((level_q[i] == MAX) || (level_q[i] > pwm_cnt_q));
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pattern_q <= '0;
         pre_q     <= '0;
         pwm_cnt_q <= '0;
         level_q   <= '0;
         led_out_q <= '0;
      end else begin
         pattern_q <= bus.pattern;
         pre_q     <= pre_d;
         pwm_cnt_q <= pwm_cnt_d;
         level_q   <= level_d;
         led_out_q <= led_out_d;
      end
   end

   assign bus.led_out = led_out_q;
   assign bus.busy    = |differs;
endmodule
